memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_array.sv | 43 ++++
 rtl/memory_responder.sv | 136 +++++++++++++
 tb/tb_memory_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared types and bus constants for the memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int DATA_W     = 64;
    localparam int TAG_W      = 8;
    localparam int BUS_AW     = 20;
    localparam int ADDR_W_DEF = 12;
    localparam int MEM_W      = DATA_W + TAG_W;

    // IDLE: no address held; ADDR: single access pending; LOCK: atomic RMW
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        LOCK = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Synchronous single-port RAM, data+tag wide, registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [MEM_W-1:0]  i_wdata,
    output logic [MEM_W-1:0]  o_rdata
);

    logic [MEM_W-1:0] mem [2**ADDR_W];
    logic [MEM_W-1:0] rdata_q;
    logic [MEM_W-1:0] rdata_d;

    // Read register only moves on a read, so it holds the last read word
    always_comb begin
        rdata_d = rdata_q;
        if (i_en && !i_we) begin
            rdata_d = mem[i_addr];
        end
    end

    // Storage array and read register; contents are never reset
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            mem[i_addr] <= i_wdata;
        end
        rdata_q <= rdata_d;
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : memory_responder
//  Description : CPU-side memory responder with address strobe, single and
//                atomic (read-then-write) accesses, sticky protocol error.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_ad,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_astb,
    input  logic              i_atomic,
    input  logic              i_rd,
    input  logic              i_wr,
    output logic [DATA_W-1:0] o_data,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_rdvalid,
    output logic              o_err
);

    state_t             state_q, state_d;
    logic [BUS_AW-1:0]  addr_q, addr_d;
    logic               rd_zero_q, rd_zero_d;
    logic               rdvalid_q, rdvalid_d;
    logic               err_q, err_d;

    logic               w_oor;
    logic               w_ram_en;
    logic               w_ram_we;
    logic [MEM_W-1:0]   w_ram_rdata;

    // Out-of-range is derived from the latched address, so it travels with it
    generate
        if (ADDR_W < BUS_AW) begin : g_range_chk
            assign w_oor = |addr_q[BUS_AW-1:ADDR_W];
        end else begin : g_full_range
            assign w_oor = 1'b0;
        end
    endgenerate

    // Next-state, access decode and error detection
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_zero_d = rd_zero_q;
        rdvalid_d = 1'b0;
        err_d     = err_q;
        w_ram_en  = 1'b0;
        w_ram_we  = 1'b0;

        if (i_astb) begin
            addr_d  = i_ad[BUS_AW-1:0];
            state_d = i_atomic ? LOCK : ADDR;
            // Access alongside a strobe is dropped; a strobe in LOCK breaks it
            if (i_rd || i_wr || state_q == LOCK) begin
                err_d = 1'b1;
            end
        end else if (i_rd && i_wr) begin
            err_d = 1'b1;
        end else if (i_rd) begin
            if (state_q == IDLE) begin
                err_d = 1'b1;
            end else begin
                rdvalid_d = 1'b1;
                if (w_oor) begin
                    rd_zero_d = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    rd_zero_d = 1'b0;
                    w_ram_en  = 1'b1;
                end
                state_d = (state_q == LOCK) ? LOCK : IDLE;
            end
        end else if (i_wr) begin
            if (state_q == IDLE) begin
                err_d = 1'b1;
            end else begin
                if (w_oor) begin
                    err_d = 1'b1;
                end else begin
                    w_ram_en = 1'b1;
                    w_ram_we = 1'b1;
                end
                state_d = IDLE;
            end
        end

        // Never let an access through on the edge reset is asserted
        if (reset) begin
            w_ram_en = 1'b0;
            w_ram_we = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_zero_q <= 1'b1;
            rdvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_zero_q <= rd_zero_d;
            rdvalid_q <= rdvalid_d;
            err_q     <= err_d;
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (addr_q[ADDR_W-1:0]),
        .i_wdata ({i_ad, i_tag}),
        .o_rdata (w_ram_rdata)
    );

    // Zero override covers reset and out-of-range reads; RAM register holds otherwise
    assign o_data    = rd_zero_q ? '0 : w_ram_rdata[MEM_W-1:TAG_W];
    assign o_tag     = rd_zero_q ? '0 : w_ram_rdata[TAG_W-1:0];
    assign o_rdvalid = rdvalid_q;
    assign o_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_responder
//  Description : Scoreboard bench for memory_responder (directed vectors).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_responder;
    import mem_bus_pkg::*;

    logic        clk;
    logic        reset;
    logic [63:0] i_ad;
    logic [7:0]  i_tag;
    logic        i_astb;
    logic        i_atomic;
    logic        i_rd;
    logic        i_wr;
    logic [63:0] o_data;
    logic [7:0]  o_tag;
    logic        o_rdvalid;
    logic        o_err;

    int n_pass;
    int n_total;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  tag;
    } rsp_t;

    rsp_t sb [$];

    memory_responder #(.ADDR_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_ad      (i_ad),
        .i_tag     (i_tag),
        .i_astb    (i_astb),
        .i_atomic  (i_atomic),
        .i_rd      (i_rd),
        .i_wr      (i_wr),
        .o_data    (o_data),
        .o_tag     (o_tag),
        .o_rdvalid (o_rdvalid),
        .o_err     (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every read-valid pulse must match the oldest expected response
    always @(negedge clk) begin
        if (o_rdvalid === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rdvalid: got data 0x%0h tag 0x%0h expected no pulse", o_data, o_tag);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rd_data", {8'h0, o_data}, {8'h0, e.data});
                check("rd_tag",  {64'h0, o_tag}, {64'h0, e.tag});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        i_astb = 1'b0; i_atomic = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
    endtask

    task automatic strobe(input logic [19:0] a, input logic atomic);
        i_astb = 1'b1; i_atomic = atomic; i_ad = {44'h0, a};
        step();
        idle_bus();
    endtask

    task automatic wr(input logic [63:0] d, input logic [7:0] t);
        i_wr = 1'b1; i_ad = d; i_tag = t;
        step();
        idle_bus();
    endtask

    task automatic rd(input logic [63:0] d, input logic [7:0] t);
        rsp_t e;
        e.data = d; e.tag = t;
        sb.push_back(e);
        i_rd = 1'b1;
        step();
        idle_bus();
    endtask

    task automatic rd_silent();
        i_rd = 1'b1;
        step();
        idle_bus();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic drain(input string name);
        // Allow two edges for any outstanding response, then it must be gone
        step();
        step();
        check(name, 72'(sb.size()), 72'd0);
        sb.delete();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        i_ad = '0; i_tag = '0;
        idle_bus();
        reset = 1'b0;
        #2;
        apply_reset();

        // Reset state
        check("rst_data",    {8'h0, o_data},    72'd0);
        check("rst_tag",     {64'h0, o_tag},    72'd0);
        check("rst_rdvalid", 72'(o_rdvalid),    72'd0);
        check("rst_err",     72'(o_err),        72'd0);
        check("rst_state",   72'(dut.state_q),  72'(IDLE));

        // Test 1: plain write then read back
        strobe(20'h00005, 1'b0);
        wr(64'h0123456789ABCDEF, 8'h3C);
        strobe(20'h00005, 1'b0);
        rd(64'h0123456789ABCDEF, 8'h3C);
        drain("t1_pending");
        check("t1_err", 72'(o_err), 72'd0);
        check("t1_hold_data", {8'h0, o_data}, {8'h0, 64'h0123456789ABCDEF});

        // Test 2: atomic read-modify-write
        strobe(20'h00010, 1'b0);
        wr(64'h11, 8'h01);
        strobe(20'h00010, 1'b1);
        check("t2_lock", 72'(dut.state_q), 72'(LOCK));
        rd(64'h11, 8'h01);
        check("t2_lock_after_rd", 72'(dut.state_q), 72'(LOCK));
        wr(64'h22, 8'h02);
        check("t2_idle_after_wr", 72'(dut.state_q), 72'(IDLE));
        strobe(20'h00010, 1'b0);
        rd(64'h22, 8'h02);
        drain("t2_pending");
        check("t2_err", 72'(o_err), 72'd0);
        check("t2_end_idle", 72'(dut.state_q), 72'(IDLE));

        // Test 3: read with no strobe
        apply_reset();
        rd_silent();
        check("t3_err", 72'(o_err), 72'd1);
        repeat (10) step();
        check("t3_err_sticky", 72'(o_err), 72'd1);

        // Test 4: out-of-range address
        apply_reset();
        strobe(20'h00000, 1'b0);
        wr(64'hAAAA, 8'h55);
        check("t4_err_pre", 72'(o_err), 72'd0);
        strobe(20'h01000, 1'b0);
        wr(64'hFF, 8'hFF);
        check("t4_err", 72'(o_err), 72'd1);
        strobe(20'h01000, 1'b0);
        rd(64'h0, 8'h0);
        strobe(20'h00000, 1'b0);
        rd(64'hAAAA, 8'h55);
        drain("t4_pending");

        // Test 5: simultaneous rd and wr
        apply_reset();
        strobe(20'h00007, 1'b0);
        wr(64'h77, 8'h07);
        strobe(20'h00007, 1'b0);
        i_rd = 1'b1; i_wr = 1'b1; i_ad = 64'hBAD; i_tag = 8'hBB;
        step();
        idle_bus();
        check("t5_err", 72'(o_err), 72'd1);
        check("t5_state_kept", 72'(dut.state_q), 72'(ADDR));
        rd(64'h77, 8'h07);
        drain("t5_pending");

        // Test 6: reset in LOCK aborts the pending write
        apply_reset();
        strobe(20'h00005, 1'b1);
        rd(64'h0123456789ABCDEF, 8'h3C);
        step();
        i_wr = 1'b1; i_ad = 64'hDEAD; i_tag = 8'hDD;
        reset = 1'b1;
        step();
        idle_bus();
        check("t6_state", 72'(dut.state_q), 72'(IDLE));
        check("t6_data",  {8'h0, o_data}, 72'd0);
        check("t6_err",   72'(o_err), 72'd0);
        reset = 1'b0;
        step();
        wr(64'hBEEF, 8'hEE);
        check("t6_wr_noastb_err", 72'(o_err), 72'd1);
        strobe(20'h00005, 1'b0);
        rd(64'h0123456789ABCDEF, 8'h3C);
        drain("t6_pending");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog: the directed sequence is short; stop rather than hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
